// File: rtl/npc_pred_pkg.sv
// Shared constants for the fetch-PC predictor: address defaults, BHT counter encodings, helpers.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package npc_pred_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam logic [31:0] ISR_ADDR_DEF = 32'h0000_4180;

    // Two-bit saturating direction counter; bit[1] is the taken prediction.
    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bht_ctr_e;

    // Number of PC bits used to index a table of the given size.
    function automatic int bht_idx_w(input int entries);
        return $clog2(entries);
    endfunction

    // Conditional-branch target: PC plus sign-extended word offset, modulo 2^32.
    function automatic logic [31:0] br_target(input logic [31:0] pc_val, input logic [15:0] off);
        return pc_val + {{14{off[15]}}, off, 2'b00};
    endfunction

endpackage

// File: rtl/npc_ras.sv
// Circular return-address stack; a push when full silently overwrites the oldest entry.
// Latency: push/pop take effect at the next rising edge; top/empty/full are registered state.
// Backpressure: none; push has priority over pop, and a pop on an empty stack is ignored.
module npc_ras
    import npc_pred_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] push_data,
    output logic [31:0] top,
    output logic        empty,
    output logic        full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [31:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] sp_q, sp_d, sp_inc;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // sp_q addresses the current top entry; a push pre-increments into the next slot,
    // which once the stack is full is exactly the oldest entry.
    assign sp_inc = sp_q + PTR_W'(1);
    assign top    = mem_q[sp_q];
    assign empty  = (cnt_q == '0);
    assign full   = (cnt_q == CNT_W'(DEPTH));

    // Pointer and occupancy next state; push wins over a simultaneous pop.
    always_comb begin
        sp_d  = sp_q;
        cnt_d = cnt_q;
        if (push) begin
            sp_d = sp_inc;
            if (!full) cnt_d = cnt_q + CNT_W'(1);
        end else if (pop && !empty) begin
            sp_d  = sp_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sp_q  <= '0;
            cnt_q <= '0;
        end else begin
            sp_q  <= sp_d;
            cnt_q <= cnt_d;
        end
    end

    // Entry storage needs no reset: occupancy gates every read that matters.
    always_ff @(posedge clk) begin
        if (push) mem_q[sp_inc] <= push_data;
    end

endmodule

// File: rtl/npc_pred.sv
// Registered fetch PC with next-PC prediction (jump decode, RAS returns, branch direction).
// Latency: pred_target is combinational from pc; redirects and predictions land in pc one edge later.
// Backpressure: stall holds pc and freezes the RAS; exc/eret/mispredict redirects override stall.
// Optional macro NPC_PRED_BHT_EN: defined -> 2-bit BHT direction predictor; undefined -> backward-taken.
module npc_pred
    import npc_pred_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = RESET_PC_DEF,
    parameter logic [31:0] ISR_ADDR    = ISR_ADDR_DEF,
    parameter int          BHT_ENTRIES = 64,
    parameter int          RAS_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        f_is_branch,
    input  logic        f_is_j,
    input  logic        f_is_call,
    input  logic        f_is_ret,
    input  logic [15:0] f_offset,
    input  logic [25:0] f_jnum,
    input  logic        r_valid,
    input  logic [31:0] r_pc,
    input  logic        r_taken,
    input  logic        r_mispredict,
    input  logic [31:0] r_target,
    input  logic        exc_req,
    input  logic        eret_req,
    input  logic [31:0] epc,
    output logic [31:0] pc,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        ras_empty,
    output logic        ras_full
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] pc_plus4, pc_plus8;
    logic [31:0] ras_top;
    logic        redirect;
    logic        ras_push, ras_pop;
    logic        dir_taken;

    assign pc       = pc_q;
    assign pc_plus4 = pc_q + 32'd4;
    assign pc_plus8 = pc_q + 32'd8;
    assign redirect = exc_req | eret_req | (r_valid & r_mispredict);

    // The RAS only follows the fetch stream that actually advances; redirected or
    // stalled fetch words never touch it, and a call+ret word counts as a call.
    assign ras_push = f_is_call & ~stall & ~redirect;
    assign ras_pop  = f_is_ret & ~f_is_call & ~stall & ~redirect & ~ras_empty;

`ifdef NPC_PRED_BHT_EN
    localparam int IDX_W = bht_idx_w(BHT_ENTRIES);

    logic [1:0]       bht_q [BHT_ENTRIES];
    logic [IDX_W-1:0] rd_idx, wr_idx;
    logic             unused_r_pc;

    assign rd_idx      = pc_q[IDX_W+1:2];
    assign wr_idx      = r_pc[IDX_W+1:2];
    assign dir_taken   = bht_q[rd_idx][1];
    assign unused_r_pc = ^{r_pc[31:IDX_W+2], r_pc[1:0]};

    // Saturating counter training from execute; independent of stall, no read bypass.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= WNT;
        end else if (r_valid) begin
            if (r_taken) begin
                if (bht_q[wr_idx] != ST) bht_q[wr_idx] <= bht_q[wr_idx] + 2'd1;
            end else begin
                if (bht_q[wr_idx] != SNT) bht_q[wr_idx] <= bht_q[wr_idx] - 2'd1;
            end
        end
    end
`else
    // Static direction: backward branches (negative offset) are loops, predict taken.
    localparam int unused_bht_entries = BHT_ENTRIES;
    logic          unused_resolve;

    assign dir_taken      = f_offset[15];
    assign unused_resolve = ^{r_pc, r_taken};
`endif

    npc_ras #(
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (clk),
        .reset_n   (reset_n),
        .push      (ras_push),
        .pop       (ras_pop),
        .push_data (pc_plus8),
        .top       (ras_top),
        .empty     (ras_empty),
        .full      (ras_full)
    );

    // Predicted successor of the current fetch word; the first matching hint wins.
    always_comb begin
        pred_target = pc_plus4;
        pred_taken  = 1'b0;
        if (f_is_j) begin
            pred_target = {pc_q[31:28], f_jnum, 2'b00};
            pred_taken  = 1'b1;
        end else if (f_is_ret) begin
            if (!ras_empty) begin
                pred_target = ras_top;
                pred_taken  = 1'b1;
            end
        end else if (f_is_branch && dir_taken) begin
            pred_target = br_target(pc_q, f_offset);
            pred_taken  = 1'b1;
        end
    end

    // Next fetch PC: later-stage redirects first, then stall, then the prediction.
    always_comb begin
        pc_d = pred_target;
        if (exc_req)                     pc_d = ISR_ADDR;
        else if (eret_req)               pc_d = epc;
        else if (r_valid && r_mispredict) pc_d = r_target;
        else if (stall)                  pc_d = pc_q;
    end

    // Fetch PC register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) pc_q <= RESET_PC;
        else          pc_q <= pc_d;
    end

endmodule

// File: tb/tb_npc_pred.sv
// Testbench for npc_pred: directed scenarios with literal expectations plus randomized traffic
// checked every cycle against a queue/array reference model.
// Works in both builds of NPC_PRED_BHT_EN.
module tb_npc_pred;

    localparam logic [31:0] RESET_PC    = 32'h0000_3000;
    localparam logic [31:0] ISR_ADDR    = 32'h0000_4180;
    localparam int          BHT_ENTRIES = 64;
    localparam int          RAS_DEPTH   = 8;

    logic        clk;
    logic        reset_n;
    logic        stall;
    logic        f_is_branch, f_is_j, f_is_call, f_is_ret;
    logic [15:0] f_offset;
    logic [25:0] f_jnum;
    logic        r_valid, r_taken, r_mispredict;
    logic [31:0] r_pc, r_target;
    logic        exc_req, eret_req;
    logic [31:0] epc;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ras_empty, ras_full;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [31:0] m_pc;
    int          m_bht [BHT_ENTRIES];
    logic [31:0] m_ras [$];

    npc_pred #(
        .RESET_PC    (RESET_PC),
        .ISR_ADDR    (ISR_ADDR),
        .BHT_ENTRIES (BHT_ENTRIES),
        .RAS_DEPTH   (RAS_DEPTH)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .f_is_branch  (f_is_branch),
        .f_is_j       (f_is_j),
        .f_is_call    (f_is_call),
        .f_is_ret     (f_is_ret),
        .f_offset     (f_offset),
        .f_jnum       (f_jnum),
        .r_valid      (r_valid),
        .r_pc         (r_pc),
        .r_taken      (r_taken),
        .r_mispredict (r_mispredict),
        .r_target     (r_target),
        .exc_req      (exc_req),
        .eret_req     (eret_req),
        .epc          (epc),
        .pc           (pc),
        .pred_taken   (pred_taken),
        .pred_target  (pred_target),
        .ras_empty    (ras_empty),
        .ras_full     (ras_full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_inputs();
        stall = 0; f_is_branch = 0; f_is_j = 0; f_is_call = 0; f_is_ret = 0;
        f_offset = '0; f_jnum = '0;
        r_valid = 0; r_pc = '0; r_taken = 0; r_mispredict = 0; r_target = '0;
        exc_req = 0; eret_req = 0; epc = '0;
    endtask

    function automatic void model_reset();
        m_pc = RESET_PC;
        for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
        m_ras.delete();
    endfunction

    // What the next fetch address should be, from the prediction rules.
    function automatic void model_predict(output logic [31:0] tgt, output logic tk);
        bit dir;
`ifdef NPC_PRED_BHT_EN
        dir = (m_bht[int'((m_pc >> 2) % BHT_ENTRIES)] >= 2);
`else
        dir = f_offset[15];
`endif
        tgt = m_pc + 32'd4;
        tk  = 1'b0;
        if (f_is_j) begin
            tgt = {m_pc[31:28], f_jnum, 2'b00};
            tk  = 1'b1;
        end else if (f_is_ret) begin
            if (m_ras.size() > 0) begin
                tgt = m_ras[$];
                tk  = 1'b1;
            end
        end else if (f_is_branch && dir) begin
            tgt = m_pc + (32'($signed(f_offset)) << 2);
            tk  = 1'b1;
        end
    endfunction

    function automatic void model_advance(input logic [31:0] tgt);
        bit redir;
        int idx;
        redir = exc_req || eret_req || (r_valid && r_mispredict);
        if (!stall && !redir) begin
            if (f_is_call) begin
                m_ras.push_back(m_pc + 32'd8);
                if (m_ras.size() > RAS_DEPTH) void'(m_ras.pop_front());
            end else if (f_is_ret && m_ras.size() > 0) begin
                void'(m_ras.pop_back());
            end
        end
        if (r_valid) begin
            idx = int'((r_pc >> 2) % BHT_ENTRIES);
            if (r_taken) m_bht[idx] = (m_bht[idx] == 3) ? 3 : m_bht[idx] + 1;
            else         m_bht[idx] = (m_bht[idx] == 0) ? 0 : m_bht[idx] - 1;
        end
        if (exc_req)                     m_pc = ISR_ADDR;
        else if (eret_req)               m_pc = epc;
        else if (r_valid && r_mispredict) m_pc = r_target;
        else if (!stall)                 m_pc = tgt;
    endfunction

    // One cycle: compare every output against the model at the falling edge, then advance.
    task automatic tick();
        logic [31:0] e_tgt;
        logic        e_tk;
        @(negedge clk);
        model_predict(e_tgt, e_tk);
        chk("pc", pc, m_pc);
        chk("pred_target", pred_target, e_tgt);
        chk("pred_taken", {31'd0, pred_taken}, {31'd0, e_tk});
        chk("ras_empty", {31'd0, ras_empty}, {31'd0, m_ras.size() == 0});
        chk("ras_full", {31'd0, ras_full}, {31'd0, m_ras.size() == RAS_DEPTH});
        model_advance(e_tgt);
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n = 1'b1;
        clear_inputs();
        #1 reset_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_pc", pc, 32'h0000_3000);
        chk("reset_ras_empty", {31'd0, ras_empty}, 32'd1);
        chk("reset_ras_full", {31'd0, ras_full}, 32'd0);
        model_reset();
        reset_n = 1'b1;

        // Sequential fetch with no hints
        tick(); chk("seq1", pc, 32'h0000_3004);
        tick(); chk("seq2", pc, 32'h0000_3008);
        tick(); chk("seq3", pc, 32'h0000_300C);
        tick(); chk("seq4", pc, 32'h0000_3010);

        // Backward branch at 0x3010, trained taken twice while stalled
        f_is_branch = 1; f_offset = 16'hFFFC; stall = 1;
        r_valid = 1; r_pc = 32'h0000_3010; r_taken = 1;
        #1;
`ifdef NPC_PRED_BHT_EN
        chk("br_fresh_taken", {31'd0, pred_taken}, 32'd0);
        chk("br_fresh_target", pred_target, 32'h0000_3014);
`else
        chk("br_fresh_taken", {31'd0, pred_taken}, 32'd1);
        chk("br_fresh_target", pred_target, 32'h0000_3000);
`endif
        tick();
        tick();
        stall = 0; r_valid = 0; r_taken = 0; r_pc = '0;
        #1;
        chk("br_trained_target", pred_target, 32'h0000_3000);
        chk("br_trained_taken", {31'd0, pred_taken}, 32'd1);
        tick(); chk("br_taken_pc", pc, 32'h0000_3000);
        clear_inputs();

        // Mispredict redirect to 0x3020
        r_valid = 1; r_mispredict = 1; r_target = 32'h0000_3020; r_pc = 32'h0000_3100;
        tick(); chk("mispred_pc", pc, 32'h0000_3020);
        clear_inputs();

        // jal at 0x3020 to 0x3040, then jr $ra
        f_is_j = 1; f_is_call = 1; f_jnum = 26'h000_0C10;
        #1 chk("jal_target", pred_target, 32'h0000_3040);
        tick(); chk("jal_ras_nonempty", {31'd0, ras_empty}, 32'd0);
        clear_inputs();
        f_is_ret = 1;
        #1;
        chk("jr_target", pred_target, 32'h0000_3028);
        chk("jr_taken", {31'd0, pred_taken}, 32'd1);
        tick();
        chk("jr_pc", pc, 32'h0000_3028);
        chk("jr_ras_empty", {31'd0, ras_empty}, 32'd1);
        clear_inputs();

        // Nine jalr pushes wrap the stack
        f_is_call = 1;
        for (int i = 0; i < 9; i++) tick();
        chk("ras_full_after9", {31'd0, ras_full}, 32'd1);
        clear_inputs();
        f_is_ret = 1;
        #1 chk("ras_ninth_pop", pred_target, 32'h0000_3050);
        tick();
        clear_inputs();

        // Redirect priority over stall
        stall = 1; r_valid = 1; r_mispredict = 1; r_target = 32'h0000_3400; exc_req = 1;
        tick(); chk("exc_prio", pc, 32'h0000_4180);
        exc_req = 0;
        tick(); chk("mispred_over_stall", pc, 32'h0000_3400);
        clear_inputs();
        eret_req = 1; epc = 32'h0000_3100;
        tick(); chk("eret_pc", pc, 32'h0000_3100);
        clear_inputs();

        // Asynchronous reset mid-cycle with a populated RAS
        reset_n = 0;
        #2;
        chk("async_rst_pc", pc, 32'h0000_3000);
        chk("async_rst_ras_empty", {31'd0, ras_empty}, 32'd1);
        model_reset();
        reset_n = 1;

        // jr with empty RAS at the top of the address space wraps to 0
        r_valid = 1; r_mispredict = 1; r_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_pc", pc, 32'hFFFF_FFFC);
        clear_inputs();
        f_is_ret = 1;
        #1;
        chk("wrap_target", pred_target, 32'h0000_0000);
        chk("wrap_taken", {31'd0, pred_taken}, 32'd0);
        tick();
        clear_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            stall        = ($urandom % 4) == 0;
            f_is_branch  = ($urandom % 3) == 0;
            f_is_j       = ($urandom % 12) == 0;
            f_is_call    = ($urandom % 5) == 0;
            f_is_ret     = ($urandom % 4) == 0;
            f_offset     = 16'($urandom);
            f_jnum       = 26'($urandom);
            r_valid      = ($urandom % 2) == 0;
            r_pc         = {26'($urandom % 4), 4'($urandom), 2'b00} + m_pc;
            r_taken      = (n % 400 < 200) ? (($urandom % 5) != 0) : (($urandom % 5) == 0);
            r_mispredict = r_valid && (($urandom % 8) == 0);
            r_target     = {$urandom} & 32'hFFFF_FFFC;
            exc_req      = ($urandom % 60) == 0;
            eret_req     = ($urandom % 60) == 0;
            epc          = {$urandom} & 32'hFFFF_FFFC;
            if (($urandom % 300) == 0) begin
                reset_n = 0;
                #1;
                model_reset();
                reset_n = 1;
            end
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/npc_pred.md
Name: npc_pred

Overview:
- Registered fetch-PC generator and predictor for the five-stage MIPS pipeline; the successor of the combinational next-PC unit.
- Holds the architectural fetch PC and predicts the next fetch address from predecode hints. Uses a parametrised 2-bit branch history table (BHT) and a circular return-address stack (RAS).
- Accepts redirects from later stages: execute-stage resolve/mispredict, exception entry, and eret.

Parameters:
- RESET_PC, 32'h0000_3000, fetch PC after reset.
- ISR_ADDR, 32'h0000_4180, exception entry address.
- BHT_ENTRIES, 64, number of counters; power of two, ≥2.
- RAS_DEPTH, 8, return-stack entries; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- stall  in  1  hold fetch PC (hazard unit).
- f_is_branch  in  1  current fetch word is a conditional branch.
- f_is_j  in  1  j or jal.
- f_is_call  in  1  jal or jalr.
- f_is_ret  in  1  jr $ra.
- f_offset  in  16  branch immediate.
- f_jnum  in  26  jump index.
- r_valid  in  1  execute resolve valid.
- r_pc  in  32  PC of the resolved branch.
- r_taken  in  1  actual direction.
- r_mispredict  in  1  prediction was wrong.
- r_target  in  32  correct next PC.
- exc_req  in  1  exception taken.
- eret_req  in  1  eret committed.
- epc  in  32  return address for eret.
- pc  out  32  current fetch PC (registered).
- pred_taken  out  1  prediction for the current fetch word; carried down the pipe.
- pred_target  out  32  predicted next PC, combinational.
- ras_empty  out  1  RAS holds no entries.
- ras_full  out  1  RAS holds RAS_DEPTH entries.

Behaviour:
- Reset, asynchronous, while reset_n=0:
  - pc=RESET_PC.
  - All BHT counters = 2'b01 (weakly not-taken).
  - RAS count=0, top pointer=0; ras_empty=1, ras_full=0.
  - Reset mid-operation discards all state immediately.
- Prediction, combinational from pc and f_* inputs, first match wins:
  - f_is_j → {pc[31:28], f_jnum, 2'b00}, pred_taken=1.
  - f_is_ret and !ras_empty → RAS top, pred_taken=1.
  - f_is_ret and ras_empty → pc+4, pred_taken=0.
  - f_is_branch → pc + sext(f_offset)<<2 if the predictor says taken (pred_taken=1); else pc+4.
  - otherwise → pc+4, pred_taken=0.
  - All arithmetic is modulo 2^32; wrap-around is silent.
- Next pc at the clock edge, priority order:
  1. exc_req → ISR_ADDR.
  2. eret_req → epc.
  3. r_valid & r_mispredict → r_target.
  4. stall → hold.
  5. otherwise → pred_target.
  - Redirects (1–3) override stall. Redirect latency is one cycle.
- BHT:
  - Index = pc[log2(BHT_ENTRIES)+1:2] for reads and r_pc[same bits] for updates.
  - On r_valid: if r_taken, the counter increments, saturating at 3; otherwise it decrements, saturating at 0. The update happens regardless of stall.
  - A same-cycle read and update of the same index reads the old value (no bypass).
- RAS:
  - Push: f_is_call & !stall & no redirect → push pc+8 (delay slot).
  - Pop: f_is_ret & !stall & no redirect & !ras_empty.
  - If call and ret are both asserted, only the push is performed.
  - Push when full overwrites the oldest entry (circular); count stays RAS_DEPTH.
  - Pop when empty is a no-op.
  - Redirects do not repair the RAS.
  - exc_req does not alter the RAS.

Optional Feature:
- Macro NPC_PRED_BHT_EN.
- Defined: direction comes from BHT counter bit[1], as above.
- Undefined: no BHT storage. Static rule: taken iff f_offset[15]=1 (backward). r_valid still drives redirects.

Decomposition:
- Shared header npc_pred.h holds:
  - RESET_PC / ISR_ADDR defaults.
  - Counter encodings: SNT=0, WNT=1, WT=2, ST=3.
  - Index-width macro.
- Sub-module npc_ras implements the circular stack:
  - Inputs: push, pop, push_data.
  - Outputs: top, empty, full.
  - Parameter: DEPTH.

Test Plan:
- Release reset → pc=0x3000. Run 3 unstalled cycles with no hints → pc=0x3004, 0x3008, 0x300C.
- Branch at pc=0x3010, f_offset=16'hFFFC, fresh BHT → pred_taken=0 (1 when BHT macro off), pred_target=0x3014. Two r_valid r_taken=1 updates for 0x3010 → next fetch of 0x3010 predicts 0x3000.
- jal at 0x3020 → RAS top=0x3028, ras_empty=0. Later jr $ra → pred_target=0x3028, ras_empty=1. With RAS_DEPTH=8, nine pushes → ras_full=1 and the first pop returns the ninth address.
- Same cycle: stall=1, r_mispredict=1, r_target=0x3400, exc_req=1 → pc=0x4180. With exc_req=0 instead → pc=0x3400.
- eret_req with epc=0x3100 → pc=0x3100. reset_n low mid-run → pc=0x3000 asynchronously and ras_empty=1.
- jr with empty RAS at pc=0xFFFF_FFFC → pred_target=0x0000_0000, pred_taken=0.
